// File: rtl/sprite_fetch.sv
// sprite_fetch: read-side engine for the sprite frame ROMs.
// Converts the VGA scan position and the shadowed character position/facing
// into a ROM read address, carries hit flags alongside the ROM's one-cycle read
// latency, and emits a pixel-aligned palette index and valid flag three cycles
// after the scan position is sampled. Also runs the walk-cycle animation FSM
// that selects which frame ROM is read.
module sprite_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 48,
    parameter int ADDR_W      = 11,
    parameter int PIX_W       = 4,
    parameter int NUM_FRAMES  = 3,
    parameter int FRAME_HOLD  = 8,
    parameter int TRANSPARENT = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              walking,
    input  logic              facing_left,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_sel,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_index,
    output logic [1:0]        anim_frame
);

    // Geometry constants in the 11-bit domain so that sx+SPR_W never wraps.
    localparam logic [10:0] SPR_W_L  = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L  = 11'(SPR_H);
    localparam logic [10:0] SPR_W_M1 = 11'(SPR_W - 1);

    localparam int          HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [1:0]        FRAME_LAST = 2'(NUM_FRAMES - 1);
    localparam logic [PIX_W-1:0]  TRANS_IDX  = PIX_W'(TRANSPARENT);

    typedef enum logic [0:0] {
        ST_STAND = 1'b0,
        ST_WALK  = 1'b1
    } anim_state_t;

    // Shadow copies of the character placement, stable for a whole frame.
    logic [9:0]  sx_r;
    logic [9:0]  sy_r;
    logic        face_r;

    // Scan-side combinational results.
    logic [10:0]       x_ext_s;
    logic [10:0]       y_ext_s;
    logic [10:0]       sx_ext_s;
    logic [10:0]       sy_ext_s;
    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    logic [10:0]       lx_s;
    logic              hit_s;
    logic [ADDR_W-1:0] addr_s;

    // Hit flags travelling alongside the ROM access.
    logic hit_d1_r;
    logic hit_d2_r;

    // Animation FSM state.
    anim_state_t       state_r;
    anim_state_t       state_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic [1:0]        frame_s;
    logic [HOLD_W-1:0] step_hold_s;
    logic [1:0]        step_frame_s;

    // Latch position and facing only at vertical blank to avoid tearing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_r   <= 10'd0;
            sy_r   <= 10'd0;
            face_r <= 1'b0;
        end else if (frame_start) begin
            sx_r   <= sprite_x;
            sy_r   <= sprite_y;
            face_r <= facing_left;
        end else begin
            sx_r   <= sx_r;
            sy_r   <= sy_r;
            face_r <= face_r;
        end
    end

    // Hit test and local-coordinate address generation (mirrored when facing left).
    always_comb begin
        x_ext_s  = {1'b0, DrawX};
        y_ext_s  = {1'b0, DrawY};
        sx_ext_s = {1'b0, sx_r};
        sy_ext_s = {1'b0, sy_r};
        hit_s    = (x_ext_s >= sx_ext_s) && (x_ext_s < (sx_ext_s + SPR_W_L)) &&
                   (y_ext_s >= sy_ext_s) && (y_ext_s < (sy_ext_s + SPR_H_L));
        dx_s     = x_ext_s - sx_ext_s;
        dy_s     = y_ext_s - sy_ext_s;
        if (face_r) begin
            lx_s = SPR_W_M1 - dx_s;
        end else begin
            lx_s = dx_s;
        end
        if (hit_s) begin
            addr_s = ADDR_W'((dy_s * SPR_W_L) + lx_s);
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Three-stage fetch pipeline: address, ROM read, palette index qualify.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= {ADDR_W{1'b0}};
            hit_d1_r  <= 1'b0;
            hit_d2_r  <= 1'b0;
            pix_valid <= 1'b0;
            pix_index <= {PIX_W{1'b0}};
        end else begin
            rom_addr  <= addr_s;
            hit_d1_r  <= hit_s;
            hit_d2_r  <= hit_d1_r;
            pix_valid <= hit_d2_r && (rom_data != TRANS_IDX);
            pix_index <= hit_d2_r ? rom_data : {PIX_W{1'b0}};
        end
    end

    // Animation next-state: the pulse that starts walking counts as the first walk step.
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        frame_s = anim_frame;
        if (hold_r == HOLD_LAST) begin
            step_hold_s = {HOLD_W{1'b0}};
            if (anim_frame == FRAME_LAST) begin
                step_frame_s = 2'd0;
            end else begin
                step_frame_s = anim_frame + 2'd1;
            end
        end else begin
            step_hold_s  = hold_r + HOLD_W'(1'b1);
            step_frame_s = anim_frame;
        end
        case (state_r)
            ST_STAND: begin
                if (frame_start && walking) begin
                    state_s = ST_WALK;
                    hold_s  = step_hold_s;
                    frame_s = step_frame_s;
                end else begin
                    state_s = ST_STAND;
                    hold_s  = {HOLD_W{1'b0}};
                    frame_s = 2'd0;
                end
            end
            ST_WALK: begin
                if (frame_start) begin
                    if (walking) begin
                        state_s = ST_WALK;
                        hold_s  = step_hold_s;
                        frame_s = step_frame_s;
                    end else begin
                        state_s = ST_STAND;
                        hold_s  = {HOLD_W{1'b0}};
                        frame_s = 2'd0;
                    end
                end else begin
                    state_s = ST_WALK;
                    hold_s  = hold_r;
                    frame_s = anim_frame;
                end
            end
            default: begin
                state_s = ST_STAND;
                hold_s  = {HOLD_W{1'b0}};
                frame_s = 2'd0;
            end
        endcase
    end

    // Animation state register; rom_sel is loaded with the same value as anim_frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_STAND;
            hold_r     <= {HOLD_W{1'b0}};
            anim_frame <= 2'd0;
            rom_sel    <= 2'd0;
        end else begin
            state_r    <= state_s;
            hold_r     <= hold_s;
            anim_frame <= frame_s;
            rom_sel    <= frame_s;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed testbench for sprite_fetch. A small synchronous ROM model returns
// (addr[3:0] + 1) mod 16 one cycle after the address, so palette indices are
// predictable by hand and addresses with low nibble 15 read as transparent.
module tb_sprite_fetch;

    logic        Clk;
    logic        Reset;
    logic        frame_start;
    logic        walking;
    logic        facing_left;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [10:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [3:0]  rom_data;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [1:0]  anim_frame;

    int checks = 0;
    int errors = 0;

    sprite_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .walking     (walking),
        .facing_left (facing_left),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_sel     (rom_sel),
        .rom_data    (rom_data),
        .pix_valid   (pix_valid),
        .pix_index   (pix_index),
        .anim_frame  (anim_frame)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM model: one-cycle registered read.
    always @(posedge Clk) rom_data <= rom_addr[3:0] + 4'd1;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        DrawX = 10'd700;
        DrawY = 10'd500;
    endtask

    task automatic set_sprite(input logic [9:0] x, input logic [9:0] y, input logic f);
        sprite_x    = x;
        sprite_y    = y;
        facing_left = f;
        idle();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (rom_addr !== 11'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        checks++; if (rom_sel !== 2'd0) begin errors++; $display("FAIL reset_rom_sel: got %0d expected 0", rom_sel); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %0b expected 0", pix_valid); end
        checks++; if (pix_index !== 4'd0) begin errors++; $display("FAIL reset_pix_index: got %0d expected 0", pix_index); end
        checks++; if (anim_frame !== 2'd0) begin errors++; $display("FAIL reset_anim_frame: got %0d expected 0", anim_frame); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_sprite(10'd100, 10'd200, 1'b0);
        sprite_x = 10'd500;  // mid-frame change must be ignored
        DrawX = 10'd100; DrawY = 10'd200; tick();
        checks++; if (rom_addr !== 11'd0) begin errors++; $display("FAIL basic_addr_tl: got %0d expected 0", rom_addr); end
        DrawX = 10'd131; DrawY = 10'd247; tick();
        checks++; if (rom_addr !== 11'd1535) begin errors++; $display("FAIL basic_addr_br: got %0d expected 1535", rom_addr); end
        DrawX = 10'd110; DrawY = 10'd210; tick();
        checks++; if (rom_addr !== 11'd330) begin errors++; $display("FAIL basic_addr_mid: got %0d expected 330", rom_addr); end
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd1) begin errors++; $display("FAIL basic_pix_tl: got v=%0b i=%0d expected v=1 i=1", pix_valid, pix_index); end
        idle(); tick();
        checks++; if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin errors++; $display("FAIL basic_pix_br: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
        tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd11) begin errors++; $display("FAIL basic_pix_mid: got v=%0b i=%0d expected v=1 i=11", pix_valid, pix_index); end
        tick();
        checks++; if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin errors++; $display("FAIL basic_pix_miss: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
    endtask

    task automatic test_facing();
        set_sprite(10'd100, 10'd200, 1'b1);
        DrawX = 10'd100; DrawY = 10'd200; tick();
        checks++; if (rom_addr !== 11'd31) begin errors++; $display("FAIL facing_addr_left: got %0d expected 31", rom_addr); end
        DrawX = 10'd131; DrawY = 10'd200; tick();
        checks++; if (rom_addr !== 11'd0) begin errors++; $display("FAIL facing_addr_right: got %0d expected 0", rom_addr); end
        DrawX = 10'd110; DrawY = 10'd205; tick();
        checks++; if (rom_addr !== 11'd181) begin errors++; $display("FAIL facing_addr_mid: got %0d expected 181", rom_addr); end
        checks++; if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin errors++; $display("FAIL facing_pix_left: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
        idle(); tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd1) begin errors++; $display("FAIL facing_pix_right: got v=%0b i=%0d expected v=1 i=1", pix_valid, pix_index); end
        tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd6) begin errors++; $display("FAIL facing_pix_mid: got v=%0b i=%0d expected v=1 i=6", pix_valid, pix_index); end
    endtask

    task automatic test_clip();
        int          xs [0:15];
        logic [10:0] ea [0:15];
        logic        ev [0:15];
        logic [3:0]  ei [0:15];
        set_sprite(10'd630, 10'd200, 1'b0);
        for (int i = 0; i < 16; i++) begin
            xs[i] = (i < 15) ? (625 + i) : 0;
            if (xs[i] >= 630) begin
                ea[i] = 11'(xs[i] - 630);
                ev[i] = 1'b1;
                ei[i] = 4'(xs[i] - 630) + 4'd1;
            end else begin
                ea[i] = 11'd0;
                ev[i] = 1'b0;
                ei[i] = 4'd0;
            end
        end
        DrawY = 10'd200;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) DrawX = 10'(xs[c]);
            else        DrawX = 10'd700;
            tick();
            if (c < 16) begin
                checks++;
                if (rom_addr !== ea[c]) begin errors++; $display("FAIL clip_addr x=%0d: got %0d expected %0d", xs[c], rom_addr, ea[c]); end
            end
            if (c >= 2) begin
                checks++;
                if (pix_valid !== ev[c-2] || pix_index !== ei[c-2]) begin
                    errors++;
                    $display("FAIL clip_pix x=%0d: got v=%0b i=%0d expected v=%0b i=%0d", xs[c-2], pix_valid, pix_index, ev[c-2], ei[c-2]);
                end
            end
        end
    endtask

    task automatic test_transparent();
        set_sprite(10'd100, 10'd200, 1'b0);
        DrawX = 10'd115; DrawY = 10'd200; tick();
        checks++; if (rom_addr !== 11'd15) begin errors++; $display("FAIL transp_addr: got %0d expected 15", rom_addr); end
        DrawX = 10'd104; DrawY = 10'd200; tick();
        checks++; if (rom_addr !== 11'd4) begin errors++; $display("FAIL opaque_addr: got %0d expected 4", rom_addr); end
        idle(); tick();
        checks++; if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin errors++; $display("FAIL transp_pix: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
        tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd5) begin errors++; $display("FAIL opaque_pix: got v=%0b i=%0d expected v=1 i=5", pix_valid, pix_index); end
    endtask

    task automatic test_vblank_edge();
        // Shadows are (100,200,left=0); new placement arrives with an in-sprite sample.
        sprite_x = 10'd300; sprite_y = 10'd200; facing_left = 1'b0;
        DrawX = 10'd101; DrawY = 10'd200;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (rom_addr !== 11'd1) begin errors++; $display("FAIL vblank_old_shadow: got %0d expected 1", rom_addr); end
        tick();
        checks++; if (rom_addr !== 11'd0) begin errors++; $display("FAIL vblank_new_miss: got %0d expected 0", rom_addr); end
        DrawX = 10'd301; tick();
        checks++; if (rom_addr !== 11'd1) begin errors++; $display("FAIL vblank_new_hit: got %0d expected 1", rom_addr); end
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd2) begin errors++; $display("FAIL vblank_pix_old: got v=%0b i=%0d expected v=1 i=2", pix_valid, pix_index); end
        idle(); tick();
        checks++; if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin errors++; $display("FAIL vblank_pix_miss: got v=%0b i=%0d expected v=0 i=0", pix_valid, pix_index); end
        tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd2) begin errors++; $display("FAIL vblank_pix_new: got v=%0b i=%0d expected v=1 i=2", pix_valid, pix_index); end
    endtask

    task automatic test_anim();
        idle();
        walking = 1'b1;
        pulse_n(7);
        checks++; if (anim_frame !== 2'd0) begin errors++; $display("FAIL anim_7: got %0d expected 0", anim_frame); end
        pulse_n(1);
        checks++; if (anim_frame !== 2'd1 || rom_sel !== 2'd1) begin errors++; $display("FAIL anim_8: got f=%0d s=%0d expected 1", anim_frame, rom_sel); end
        tick(); tick(); tick(); tick(); tick();
        checks++; if (anim_frame !== 2'd1) begin errors++; $display("FAIL anim_hold_no_pulse: got %0d expected 1", anim_frame); end
        pulse_n(8);
        checks++; if (anim_frame !== 2'd2 || rom_sel !== 2'd2) begin errors++; $display("FAIL anim_16: got f=%0d s=%0d expected 2", anim_frame, rom_sel); end
        pulse_n(7);
        checks++; if (anim_frame !== 2'd2) begin errors++; $display("FAIL anim_23: got %0d expected 2", anim_frame); end
        pulse_n(1);
        checks++; if (anim_frame !== 2'd0 || rom_sel !== 2'd0) begin errors++; $display("FAIL anim_24_wrap: got f=%0d s=%0d expected 0", anim_frame, rom_sel); end
        pulse_n(8);
        checks++; if (anim_frame !== 2'd1) begin errors++; $display("FAIL anim_32: got %0d expected 1", anim_frame); end
        walking = 1'b0;
        pulse_n(1);
        checks++; if (anim_frame !== 2'd0 || rom_sel !== 2'd0) begin errors++; $display("FAIL anim_stop: got f=%0d s=%0d expected 0", anim_frame, rom_sel); end
        walking = 1'b1;
        pulse_n(7);
        checks++; if (anim_frame !== 2'd0) begin errors++; $display("FAIL anim_restart_7: got %0d expected 0", anim_frame); end
        pulse_n(1);
        checks++; if (anim_frame !== 2'd1) begin errors++; $display("FAIL anim_restart_8: got %0d expected 1", anim_frame); end
        walking = 1'b0;
    endtask

    task automatic test_reset_mid();
        // anim_frame is 1 here; shadows are (300,200,left=0).
        DrawX = 10'd310; DrawY = 10'd205;
        tick(); tick(); tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd11 || rom_addr !== 11'd170) begin
            errors++; $display("FAIL pre_reset_stream: got v=%0b i=%0d a=%0d expected v=1 i=11 a=170", pix_valid, pix_index, rom_addr);
        end
        Reset = 1'b1;
        DrawX = 10'd10; DrawY = 10'd5;
        tick();
        checks++; if (rom_addr !== 11'd0 || rom_sel !== 2'd0 || anim_frame !== 2'd0 || pix_valid !== 1'b0 || pix_index !== 4'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got a=%0d s=%0d f=%0d v=%0b i=%0d expected all 0", rom_addr, rom_sel, anim_frame, pix_valid, pix_index);
        end
        Reset = 1'b0;
        tick();
        checks++; if (pix_valid !== 1'b0 || rom_addr !== 11'd170) begin errors++; $display("FAIL post_reset_1: got v=%0b a=%0d expected v=0 a=170", pix_valid, rom_addr); end
        tick();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL post_reset_2: got v=%0b expected 0", pix_valid); end
        tick();
        checks++; if (pix_valid !== 1'b1 || pix_index !== 4'd11) begin errors++; $display("FAIL post_reset_3: got v=%0b i=%0d expected v=1 i=11", pix_valid, pix_index); end
    endtask

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        walking     = 1'b0;
        facing_left = 1'b0;
        sprite_x    = 10'd0;
        sprite_y    = 10'd0;
        DrawX       = 10'd700;
        DrawY       = 10'd500;
        test_reset();
        test_basic();
        test_facing();
        test_clip();
        test_transparent();
        set_sprite(10'd100, 10'd200, 1'b0);
        test_vblank_edge();
        test_anim();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
